// File: rtl/uart_shift_reg_p.sv
// rtl/uart_shift_reg_p.sv - parametrised load/shift register for the UART datapath
//
// Parallel-loads a WIDTH-bit word, serialises it LSB- or MSB-first while
// capturing a serial input, and counts shifts since the last load with a
// one-cycle done pulse after the WIDTH-th shift. Shared by the TX serialiser
// (so) and the RX deserialiser (si -> dout).
//
// Optional feature macro: SHIFT_REG_PARITY_EN adds the parity output.
//
// Parameters:
//   WIDTH     data word width (>= 2)
//   LSB_FIRST 1: shift toward bit 0, si enters at WIDTH-1; 0: the reverse
// Ports:
//   clk_in   in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   ld       in   parallel load strobe (wins over shift)
//   shift    in   shift-one-bit strobe
//   din      in   parallel load data
//   si       in   serial input bit
//   so       out  serial output bit (current end bit of the register)
//   dout     out  register contents
//   bit_cnt  out  shifts completed since the last load
//   busy     out  high from load until WIDTH shifts have completed
//   parity   out  XOR-reduction of dout (SHIFT_REG_PARITY_EN only)
//   done     out  one-cycle pulse after the WIDTH-th shift

module uart_shift_reg_p #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     ld,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         din,
    input  logic                     si,
    output logic                     so,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     busy,
`ifdef SHIFT_REG_PARITY_EN
    output logic                     parity,
`endif
    output logic                     done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        // done is a pulse: it only survives one cycle unless re-set below
        done_d = 1'b0;
        if (ld) begin
            data_d = din;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (shift) begin
            if (LSB_FIRST) begin
                data_d = {si, data_q[WIDTH-1:1]};
            end else begin
                data_d = {data_q[WIDTH-2:0], si};
            end
            // An idle register still moves data, but the word bookkeeping
            // only advances while a loaded word is being serialised.
            if (busy_q) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign so      = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign dout    = data_q;
    assign bit_cnt = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef SHIFT_REG_PARITY_EN
    assign parity = ^data_q;
`endif

endmodule

// File: tb/tb_uart_shift_reg_p.sv
// tb/tb_uart_shift_reg_p.sv - self-checking bench for uart_shift_reg_p

module tb_uart_shift_reg_p;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        ld;
    logic        shift;
    logic        si;
    logic [11:0] din;

    logic [7:0]  dout0, dout1;
    logic [11:0] dout2;
    logic [2:0]  cnt0, cnt1;
    logic [3:0]  cnt2;
    logic        so0, so1, so2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        par0, par1, par2;

    always #5 clk_in = ~clk_in;

    uart_shift_reg_p #(.WIDTH(8), .LSB_FIRST(1'b1)) u_d0 (
        .clk_in(clk_in), .reset(reset), .ld(ld), .shift(shift),
        .din(din[7:0]), .si(si), .so(so0), .dout(dout0), .bit_cnt(cnt0),
        .busy(busy0),
`ifdef SHIFT_REG_PARITY_EN
        .parity(par0),
`endif
        .done(done0)
    );

    uart_shift_reg_p #(.WIDTH(8), .LSB_FIRST(1'b0)) u_d1 (
        .clk_in(clk_in), .reset(reset), .ld(ld), .shift(shift),
        .din(din[7:0]), .si(si), .so(so1), .dout(dout1), .bit_cnt(cnt1),
        .busy(busy1),
`ifdef SHIFT_REG_PARITY_EN
        .parity(par1),
`endif
        .done(done1)
    );

    uart_shift_reg_p #(.WIDTH(12), .LSB_FIRST(1'b1)) u_d2 (
        .clk_in(clk_in), .reset(reset), .ld(ld), .shift(shift),
        .din(din), .si(si), .so(so2), .dout(dout2), .bit_cnt(cnt2),
        .busy(busy2),
`ifdef SHIFT_REG_PARITY_EN
        .parity(par2),
`endif
        .done(done2)
    );

`ifndef SHIFT_REG_PARITY_EN
    assign par0 = 1'b0;
    assign par1 = 1'b0;
    assign par2 = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: word as an integer, shifts counted since the last load
    int m_w   [3] = '{8, 8, 12};
    bit m_lsb [3] = '{1'b1, 1'b0, 1'b1};
    int m_val [3];
    int m_shifts [3];
    bit m_busy [3];
    bit m_done [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0; m_shifts[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            int mask;
            mask = (1 << m_w[i]) - 1;
            m_done[i] = 0;
            if (ld) begin
                m_val[i] = int'(din) & mask;
                m_shifts[i] = 0;
                m_busy[i] = 1;
            end else if (shift) begin
                if (m_lsb[i])
                    m_val[i] = (m_val[i] >> 1) | (int'(si) << (m_w[i] - 1));
                else
                    m_val[i] = ((m_val[i] << 1) | int'(si)) & mask;
                if (m_busy[i]) begin
                    m_shifts[i] = m_shifts[i] + 1;
                    if (m_shifts[i] == m_w[i]) begin
                        m_shifts[i] = 0;
                        m_busy[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end
        end
    endtask

    function automatic int exp_so(input int i);
        if (m_lsb[i]) return m_val[i] & 1;
        return (m_val[i] >> (m_w[i] - 1)) & 1;
    endfunction

    task automatic check_inst(input string nm, input int i, input logic [31:0] d,
                              input logic s, input logic [31:0] c, input logic b,
                              input logic dn, input logic p);
        check({nm, ".dout"}, d, m_val[i]);
        check({nm, ".so"}, {31'b0, s}, exp_so(i));
        check({nm, ".bit_cnt"}, c, m_shifts[i]);
        check({nm, ".busy"}, {31'b0, b}, {31'b0, m_busy[i]});
        check({nm, ".done"}, {31'b0, dn}, {31'b0, m_done[i]});
`ifdef SHIFT_REG_PARITY_EN
        check({nm, ".parity"}, {31'b0, p}, $countones(m_val[i]) % 2);
`else
        if (p !== 1'b0) check({nm, ".parity_tie"}, {31'b0, p}, 0);
`endif
    endtask

    task automatic check_all();
        check_inst("d0", 0, {24'b0, dout0}, so0, {29'b0, cnt0}, busy0, done0, par0);
        check_inst("d1", 1, {24'b0, dout1}, so1, {29'b0, cnt1}, busy1, done1, par1);
        check_inst("d2", 2, {20'b0, dout2}, so2, {28'b0, cnt2}, busy2, done2, par2);
    endtask

    // Inputs change just after a falling edge; outputs are compared at the next one.
    task automatic step(input bit l, input bit s, input bit i_si, input logic [11:0] d);
        ld = l; shift = s; si = i_si; din = d;
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
        check_all();
    endtask

    bit seq_a [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit seq_b [8]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    bit seq_c [12] = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        reset = 1'b1; ld = 1'b0; shift = 1'b0; si = 1'b0; din = '0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        check_all();
        reset = 1'b0;

        // LSB-first 0xA5, si=1
        step(1, 0, 1, 12'h0A5);
        check("a.so0", {31'b0, so0}, {31'b0, seq_a[0]});
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 1, 12'h000);
            if (k < 8) begin
                check($sformatf("a.so0[%0d]", k), {31'b0, so0}, {31'b0, seq_a[k]});
                check($sformatf("a.cnt0[%0d]", k), {29'b0, cnt0}, k);
            end
        end
        check("a.dout0", {24'b0, dout0}, 32'hFF);
        check("a.done0", {31'b0, done0}, 1);
        check("a.cnt0_wrap", {29'b0, cnt0}, 0);
        step(0, 0, 1, 12'h000);
        check("a.done0_clear", {31'b0, done0}, 0);
        check("a.busy0_low", {31'b0, busy0}, 0);

        // MSB-first 0x96, si=0
        step(1, 0, 0, 12'h096);
        check("b.so1", {31'b0, so1}, {31'b0, seq_b[0]});
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 12'h000);
            if (k < 8) check($sformatf("b.so1[%0d]", k), {31'b0, so1}, {31'b0, seq_b[k]});
        end
        check("b.dout1", {24'b0, dout1}, 0);
        check("b.done1", {31'b0, done1}, 1);
        step(0, 0, 0, 12'h000);
        check("b.done1_clear", {31'b0, done1}, 0);

        // Load and shift together, then shifts with an idle gap
        step(1, 1, 1, 12'h03C);
        check("c.dout0", {24'b0, dout0}, 32'h3C);
        check("c.cnt0", {29'b0, cnt0}, 0);
        check("c.busy0", {31'b0, busy0}, 1);
        step(0, 1, 0, 12'h000);
        step(0, 1, 0, 12'h000);
        step(0, 0, 0, 12'h000);
        check("c.gap_cnt0", {29'b0, cnt0}, 2);
        check("c.gap_dout0", {24'b0, dout0}, 32'h0F);
        step(0, 1, 0, 12'h000);
        check("c.cnt0", {29'b0, cnt0}, 3);

        // Asynchronous reset mid-word
        step(1, 0, 0, 12'h05A);
        for (int k = 0; k < 4; k++) step(0, 1, 1, 12'h000);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("r.dout0", {24'b0, dout0}, 0);
        check("r.busy0", {31'b0, busy0}, 0);
        check("r.cnt0", {29'b0, cnt0}, 0);
        check_all();
        @(negedge clk_in);
        reset = 1'b0;
        step(0, 1, 1, 12'h000);
        check("r.dout0_after", {24'b0, dout0}, 32'h80);
        check("r.done0_after", {31'b0, done0}, 0);

        // 12-bit LSB-first 0xABC, si=0
        step(1, 0, 0, 12'hABC);
        check("w.so2", {31'b0, so2}, {31'b0, seq_c[0]});
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 0, 12'h000);
            if (k < 12) begin
                check($sformatf("w.so2[%0d]", k), {31'b0, so2}, {31'b0, seq_c[k]});
                check($sformatf("w.done2[%0d]", k), {31'b0, done2}, 0);
            end
        end
        check("w.done2", {31'b0, done2}, 1);

`ifdef SHIFT_REG_PARITY_EN
        step(1, 0, 0, 12'h007);
        check("p.par_07", {31'b0, par0}, 1);
        step(1, 0, 0, 12'h0A5);
        check("p.par_a5", {31'b0, par0}, 0);
        step(0, 1, 0, 12'h000);
        check("p.dout_52", {24'b0, dout0}, 32'h52);
        check("p.par_52", {31'b0, par0}, 1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit r_ld, r_sh, r_si;
            r_ld = ($urandom_range(0, 9) == 0);
            r_sh = ($urandom_range(0, 3) != 0);
            r_si = 1'($urandom_range(0, 1));
            step(r_ld, r_sh, r_si, 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
